// File: rtl/mem_bist_1rw.sv
// mem_bist_1rw: March C- self test engine driving one 1rw memory port.
//
// Sequence over N = BANKS*WORDS locations (addr minor, bank major):
//   M0 up {W0}, M1 up {R0,W1}, M2 down {R1,W0}, M3 up {R0}, then DRAIN for
//   LATENCY cycles so the final read is compared before done rises.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               pulse; starts a run from IDLE or DONE, ignored while busy
//   read_0, write_0     memory port requests (never both)
//   bank_0, addr_0      location; zero when no request is issued
//   din_0, bw_0         write data and bit enables; zero when not writing
//   dout_0              read data, valid LATENCY cycles after read_0
//   busy, done          run in progress / run complete (held until next start)
//   fail, fail_bank,
//   fail_addr           sticky mismatch flag and first failing location
//   err_count           saturating mismatch count
module mem_bist_1rw #(
  parameter int unsigned AW      = 10,
  parameter int unsigned DW      = 32,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned WORDS   = 1024,
  parameter int unsigned BANKS   = 1,
  parameter int unsigned BAW     = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           read_0,
  output logic           write_0,
  output logic [BAW-1:0] bank_0,
  output logic [AW-1:0]  addr_0,
  output logic [DW-1:0]  din_0,
  output logic [DW-1:0]  bw_0,
  input  logic [DW-1:0]  dout_0,
  output logic           busy,
  output logic           done,
  output logic           fail,
  output logic [BAW-1:0] fail_bank,
  output logic [AW-1:0]  fail_addr,
  output logic [15:0]    err_count
);

  localparam logic [BAW-1:0] LastBank = BAW'(BANKS - 1);
  localparam logic [AW-1:0]  LastAddr = AW'(WORDS - 1);
  // Compare pipeline entry: {valid, expect_ones, bank, addr}
  localparam int unsigned    EW       = 2 + BAW + AW;

  typedef enum logic [2:0] {StIdle, StM0, StM1, StM2, StM3, StDrain, StDone} state_e;

  state_e         state_q, state_d;
  logic [BAW-1:0] bank_q, bank_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           phase_q, phase_d;  // M1/M2 only: 0 = read cycle, 1 = write cycle
  logic [4:0]     drain_q, drain_d;

  logic           rd, wr, wr_one, rd_exp_one, clear_res;
  logic           last_up, last_dn;
  logic [BAW-1:0] bank_up, bank_dn;
  logic [AW-1:0]  addr_up, addr_dn;

  // Address is the minor digit; it carries into / borrows from the bank select.
  always_comb begin
    last_up = (bank_q == LastBank) && (addr_q == LastAddr);
    last_dn = (bank_q == '0) && (addr_q == '0);
    bank_up = bank_q;
    addr_up = addr_q + 1'b1;
    if (addr_q == LastAddr) begin
      addr_up = '0;
      bank_up = bank_q + 1'b1;
    end
    bank_dn = bank_q;
    addr_dn = addr_q - 1'b1;
    if (addr_q == '0) begin
      addr_dn = LastAddr;
      bank_dn = bank_q - 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    addr_d     = addr_q;
    phase_d    = phase_q;
    drain_d    = drain_q;
    rd         = 1'b0;
    wr         = 1'b0;
    wr_one     = 1'b0;
    rd_exp_one = 1'b0;
    clear_res  = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StM0;
          bank_d    = '0;
          addr_d    = '0;
          phase_d   = 1'b0;
          clear_res = 1'b1;
        end
      end
      StM0: begin
        wr = 1'b1;
        if (last_up) begin
          state_d = StM1;
          bank_d  = '0;
          addr_d  = '0;
        end else begin
          bank_d = bank_up;
          addr_d = addr_up;
        end
      end
      StM1: begin
        if (!phase_q) begin
          rd      = 1'b1;
          phase_d = 1'b1;
        end else begin
          wr      = 1'b1;
          wr_one  = 1'b1;
          phase_d = 1'b0;
          if (last_up) begin
            state_d = StM2;
            bank_d  = LastBank;
            addr_d  = LastAddr;
          end else begin
            bank_d = bank_up;
            addr_d = addr_up;
          end
        end
      end
      StM2: begin
        if (!phase_q) begin
          rd         = 1'b1;
          rd_exp_one = 1'b1;
          phase_d    = 1'b1;
        end else begin
          wr      = 1'b1;
          phase_d = 1'b0;
          if (last_dn) begin
            state_d = StM3;
            bank_d  = '0;
            addr_d  = '0;
          end else begin
            bank_d = bank_dn;
            addr_d = addr_dn;
          end
        end
      end
      StM3: begin
        rd = 1'b1;
        if (last_up) begin
          bank_d  = '0;
          addr_d  = '0;
          state_d = (LATENCY == 0) ? StDone : StDrain;
          drain_d = 5'(LATENCY - 1);
        end else begin
          bank_d = bank_up;
          addr_d = addr_up;
        end
      end
      StDrain: begin
        if (drain_q == '0) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      bank_q  <= '0;
      addr_q  <= '0;
      phase_q <= 1'b0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
      drain_q <= drain_d;
    end
  end

  // Compare pipeline: an entry pushed with a read emerges alongside its data.
  logic [EW-1:0] ent_in, ent_out;
  assign ent_in = {rd, rd_exp_one, bank_q, addr_q};

  if (LATENCY == 0) begin : g_no_pipe
    assign ent_out = ent_in;
  end else begin : g_pipe
    localparam int unsigned PW = LATENCY * EW;
    logic [PW-1:0] pipe_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= PW'({pipe_q, ent_in});  // oldest entry falls off the top
      end
    end
    assign ent_out = pipe_q[PW-1 -: EW];
  end

  logic           cmp_vld, cmp_exp, mismatch;
  logic [BAW-1:0] cmp_bank;
  logic [AW-1:0]  cmp_addr;
  assign cmp_vld  = ent_out[EW-1];
  assign cmp_exp  = ent_out[EW-2];
  assign cmp_bank = ent_out[AW +: BAW];
  assign cmp_addr = ent_out[AW-1:0];
  assign mismatch = cmp_vld && (dout_0 != {DW{cmp_exp}});

  logic           fail_q;
  logic [BAW-1:0] fail_bank_q;
  logic [AW-1:0]  fail_addr_q;
  logic [15:0]    err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_q      <= 1'b0;
      fail_bank_q <= '0;
      fail_addr_q <= '0;
      err_q       <= '0;
    end else if (clear_res) begin
      fail_q      <= 1'b0;
      fail_bank_q <= '0;
      fail_addr_q <= '0;
      err_q       <= '0;
    end else if (mismatch) begin
      fail_q <= 1'b1;
      if (!fail_q) begin
        fail_bank_q <= cmp_bank;
        fail_addr_q <= cmp_addr;
      end
      if (err_q != 16'hFFFF) begin
        err_q <= err_q + 16'd1;
      end
    end
  end

  assign read_0    = rd;
  assign write_0   = wr;
  assign bank_0    = (rd || wr) ? bank_q : '0;
  assign addr_0    = (rd || wr) ? addr_q : '0;
  assign din_0     = (wr && wr_one) ? '1 : '0;
  assign bw_0      = wr ? '1 : '0;
  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign done      = (state_q == StDone);
  assign fail      = fail_q;
  assign fail_bank = fail_bank_q;
  assign fail_addr = fail_addr_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_mem_bist_1rw.sv
// tb_mem_bist_1rw: two instances of mem_bist_1rw (LATENCY=2 with 2 banks of 4
// words, LATENCY=0 with 1 bank of 4 words) each attached to a behavioural
// memory with optional stuck-at / single-read bit flip / corrupt-all faults.
// Port traces and result registers are checked against a March C- model.
module tb_mem_bist_1rw;

  typedef logic [20:0] op_t;  // {read, write, bank, addr[1:0], din[7:0], bw[7:0]}

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: LATENCY=2, BANKS=2
  logic       start_a = 1'b0;
  logic       rd_a, wr_a, busy_a, done_a, fail_a, bank_a, fbank_a;
  logic [1:0] addr_a, faddr_a;
  logic [7:0] din_a, bw_a, dout_a;
  logic [15:0] errc_a;

  // Instance B: LATENCY=0, BANKS=1
  logic       start_b = 1'b0;
  logic       rd_b, wr_b, busy_b, done_b, fail_b, bank_b, fbank_b;
  logic [1:0] addr_b, faddr_b;
  logic [7:0] din_b, bw_b, dout_b;
  logic [15:0] errc_b;

  mem_bist_1rw #(.AW(2), .DW(8), .LATENCY(2), .WORDS(4), .BANKS(2), .BAW(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .read_0(rd_a), .write_0(wr_a),
    .bank_0(bank_a), .addr_0(addr_a), .din_0(din_a), .bw_0(bw_a), .dout_0(dout_a),
    .busy(busy_a), .done(done_a), .fail(fail_a), .fail_bank(fbank_a),
    .fail_addr(faddr_a), .err_count(errc_a)
  );

  mem_bist_1rw #(.AW(2), .DW(8), .LATENCY(0), .WORDS(4), .BANKS(1), .BAW(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .read_0(rd_b), .write_0(wr_b),
    .bank_0(bank_b), .addr_0(addr_b), .din_0(din_b), .bw_0(bw_b), .dout_0(dout_b),
    .busy(busy_b), .done(done_b), .fail(fail_b), .fail_bank(fbank_b),
    .fail_addr(faddr_b), .err_count(errc_b)
  );

  // Fault configuration shared by the memory models and the reference model.
  bit f_stuck_en = 0, f_sval = 0, f_flip_en = 0, f_corrupt = 0;
  int f_sb = 0, f_sa = 0, f_sbit = 0, f_fb = 0, f_fa = 0, f_focc = 0, f_fbit = 0;

  function automatic logic [7:0] faulty(input int b, input int a, input logic [7:0] v,
                                        input int occ);
    logic [7:0] r;
    r = v;
    if (f_stuck_en && b == f_sb && a == f_sa) r[f_sbit] = f_sval;
    if (f_flip_en && b == f_fb && a == f_fa && occ == f_focc) r[f_fbit] = ~r[f_fbit];
    if (f_corrupt) r = r ^ 8'h01;
    return r;
  endfunction

  // Memory A: two-cycle read pipeline, counts reads per location for flips.
  logic [7:0] mem_a [2][4];
  int         rdcnt_a [2][4];
  logic [7:0] p1_a = '0, p2_a = '0;
  always @(posedge clk) begin
    if (start_a && !busy_a) begin
      for (int b = 0; b < 2; b++) for (int a = 0; a < 4; a++) rdcnt_a[b][a] <= 0;
    end
    if (wr_a) mem_a[bank_a][addr_a] <= (mem_a[bank_a][addr_a] & ~bw_a) | (din_a & bw_a);
    if (rd_a) begin
      p1_a <= faulty(int'(bank_a), int'(addr_a), mem_a[bank_a][addr_a],
                     rdcnt_a[bank_a][addr_a] + 1);
      rdcnt_a[bank_a][addr_a] <= rdcnt_a[bank_a][addr_a] + 1;
    end else begin
      p1_a <= '0;
    end
    p2_a <= p1_a;
  end
  assign dout_a = p2_a;

  // Memory B: combinational read.
  logic [7:0] mem_b [4];
  always @(posedge clk) begin
    if (wr_b) mem_b[addr_b] <= (mem_b[addr_b] & ~bw_b) | (din_b & bw_b);
  end
  assign dout_b = rd_b ? faulty(0, int'(addr_b), mem_b[addr_b], 0) : 8'h00;

  // Selected-instance view.
  int   sel = 0;
  logic cur_rd, cur_wr, cur_busy, cur_done, cur_fail, cur_bank, cur_fbank;
  logic [1:0] cur_addr, cur_faddr;
  logic [7:0] cur_din, cur_bw;
  logic [15:0] cur_errc;
  always_comb begin
    if (sel == 0) begin
      cur_rd = rd_a; cur_wr = wr_a; cur_busy = busy_a; cur_done = done_a;
      cur_fail = fail_a; cur_bank = bank_a; cur_fbank = fbank_a; cur_addr = addr_a;
      cur_faddr = faddr_a; cur_din = din_a; cur_bw = bw_a; cur_errc = errc_a;
    end else begin
      cur_rd = rd_b; cur_wr = wr_b; cur_busy = busy_b; cur_done = done_b;
      cur_fail = fail_b; cur_bank = bank_b; cur_fbank = fbank_b; cur_addr = addr_b;
      cur_faddr = faddr_b; cur_din = din_b; cur_bw = bw_b; cur_errc = errc_b;
    end
  end

  int n_checks = 0, n_errs = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference: walk March C- at the level of elements and locations.
  op_t exp_q[$];
  int  pred_errs, pred_fb, pred_fa;

  function automatic op_t mk_op(input bit r, input bit w, input int b, input int a,
                                input bit one);
    logic [7:0] d, m;
    d = (w && one) ? 8'hFF : 8'h00;
    m = w ? 8'hFF : 8'h00;
    return {r, w, b[0], a[1:0], d, m};
  endfunction

  function automatic void march_model(input int banks, input int lat, input bit use_occ);
    logic [7:0] m [2][4];
    int occ [2][4];
    int loc, b, a;
    logic [7:0] v, want;
    exp_q.delete();
    pred_errs = 0; pred_fb = 0; pred_fa = 0;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 4; j++) occ[i][j] = 0;
    for (int e = 0; e < 4; e++) begin
      for (int k = 0; k < banks * 4; k++) begin
        loc = (e == 2) ? banks * 4 - 1 - k : k;
        b = loc / 4;
        a = loc % 4;
        if (e != 0) begin
          want = (e == 2) ? 8'hFF : 8'h00;
          occ[b][a]++;
          v = faulty(b, a, m[b][a], use_occ ? occ[b][a] : 0);
          exp_q.push_back(mk_op(1'b1, 1'b0, b, a, 1'b0));
          if (v !== want) begin
            if (pred_errs == 0) begin pred_fb = b; pred_fa = a; end
            pred_errs++;
          end
        end
        if (e != 3) begin
          m[b][a] = (e == 1) ? 8'hFF : 8'h00;
          exp_q.push_back(mk_op(1'b0, 1'b1, b, a, e == 1));
        end
      end
    end
    for (int i = 0; i < lat; i++) exp_q.push_back('0);
  endfunction

  task automatic set_start(input bit v);
    if (sel == 0) start_a = v; else start_b = v;
  endtask

  task automatic run_bist(input string tag, input int which, input bit poke);
    op_t trace[$];
    int cyc, bad, prot, banks, nz;
    sel = which;
    banks = (which == 0) ? 2 : 1;
    march_model(banks, (which == 0) ? 2 : 0, which == 0);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk); set_start(1'b1);
    @(negedge clk); set_start(1'b0);
    cyc = 0; prot = 0;
    while (cur_busy && cyc < 300) begin
      trace.push_back({cur_rd, cur_wr, cur_bank, cur_addr, cur_din, cur_bw});
      if (cur_rd && cur_wr) prot++;
      if ((cur_rd || cur_wr) && (int'(cur_bank) >= banks || int'(cur_addr) >= 4)) prot++;
      set_start(poke && ($urandom_range(0, 5) == 0));
      @(negedge clk);
      cyc++;
    end
    set_start(1'b0);
    check({tag, "_busy_cycles"}, 64'(trace.size()), 64'(exp_q.size()));
    bad = 0;
    for (int i = 0; i < trace.size() && i < exp_q.size(); i++) begin
      if (trace[i] !== exp_q[i]) bad++;
    end
    check({tag, "_port_seq_bad_cycles"}, 64'(bad), 64'd0);
    check({tag, "_protocol"}, 64'(prot), 64'd0);
    check({tag, "_done"}, 64'(cur_done), 64'd1);
    check({tag, "_fail"}, 64'(cur_fail), 64'(pred_errs != 0));
    check({tag, "_err_count"}, 64'(cur_errc), 64'(pred_errs));
    check({tag, "_fail_loc"}, {32'(cur_fbank), 32'(cur_faddr)}, {32'(pred_fb), 32'(pred_fa)});
    nz = 0;
    if (which == 0) begin
      for (int b = 0; b < 2; b++) for (int a = 0; a < 4; a++) if (mem_a[b][a] !== 8'h00) nz++;
    end else begin
      for (int a = 0; a < 4; a++) if (mem_b[a] !== 8'h00) nz++;
    end
    check({tag, "_mem_zero"}, 64'(nz), 64'd0);
  endtask

  task automatic clear_faults();
    f_stuck_en = 0; f_flip_en = 0; f_corrupt = 0;
  endtask

  // Abort a run in M2 with every read corrupted, then look for stale compares.
  task automatic run_abort();
    sel = 0;
    f_corrupt = 1;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat ($urandom_range(25, 38)) @(negedge clk);
    rst = 1'b1;
    #2;
    check("abort_reset_ports", {rd_a, wr_a, bank_a, addr_a, din_a, bw_a, busy_a, done_a},
          64'd0);
    check("abort_reset_results", {fail_a, fbank_a, faddr_a, errc_a}, 64'd0);
    #1 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_no_stale", {busy_a, fail_a, errc_a}, 64'd0);
    end
    f_corrupt = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_a_ports", {rd_a, wr_a, bank_a, addr_a, din_a, bw_a, busy_a, done_a}, 64'd0);
    check("reset_a_results", {fail_a, fbank_a, faddr_a, errc_a}, 64'd0);
    check("reset_b_all", {rd_b, wr_b, bank_b, addr_b, din_b, bw_b, busy_b, done_b, fail_b,
                          fbank_b, faddr_b, errc_b}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_busy", {busy_a, busy_b, done_a, done_b}, 64'd0);

    clear_faults();
    run_bist("a_clean_poke", 0, 1'b1);

    f_flip_en = 1; f_fb = 1; f_fa = 2; f_focc = 1; f_fbit = 3;
    run_bist("a_flip_b1a2", 0, 1'b0);
    clear_faults();

    f_stuck_en = 1; f_sb = 0; f_sa = 1; f_sbit = 0; f_sval = 1;
    run_bist("a_stuck1_b0a1", 0, 1'b0);
    clear_faults();

    run_bist("b_clean", 1, 1'b1);

    run_abort();
    run_bist("a_after_abort", 0, 1'b0);

    for (int it = 0; it < 4; it++) begin
      clear_faults();
      if ($urandom_range(0, 1) == 0) begin
        f_flip_en = 1; f_fb = $urandom_range(0, 1); f_fa = $urandom_range(0, 3);
        f_focc = $urandom_range(1, 3); f_fbit = $urandom_range(0, 7);
      end else begin
        f_stuck_en = 1; f_sb = $urandom_range(0, 1); f_sa = $urandom_range(0, 3);
        f_sbit = $urandom_range(0, 7); f_sval = 1'($urandom_range(0, 1));
      end
      run_bist("a_rand", 0, 1'($urandom_range(0, 1)));
    end

    for (int it = 0; it < 2; it++) begin
      clear_faults();
      f_stuck_en = 1; f_sb = 0; f_sa = $urandom_range(0, 3);
      f_sbit = $urandom_range(0, 7); f_sval = 1'($urandom_range(0, 1));
      run_bist("b_rand_stuck", 1, 1'($urandom_range(0, 1)));
    end

    clear_faults();
    run_bist("a_final_clean", 0, 1'b0);
    run_bist("b_final_clean", 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bist_1rw.md
MEM_BIST_1RW -- requirements
Module: mem_bist_1rw

Interface
REQ-001 Parameter AW, default 10, memory word address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter LATENCY, default 2, read latency of the attached 1rw port in cycles; legal range 0..29.
REQ-004 Parameter WORDS, default 1024, words per bank.
REQ-005 Parameter BANKS, default 1, bank count.
REQ-006 Parameter BAW, default 1, bank select width; must be >= 1.
REQ-007 clk  in  1  sole clock; all state changes on posedge clk.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 start  in  1  pulse; begins a test run when the block is not busy.
REQ-010 read_0  out  1  read request to memory port.
REQ-011 write_0  out  1  write request to memory port.
REQ-012 bank_0  out  BAW  bank select.
REQ-013 addr_0  out  AW  word address.
REQ-014 din_0  out  DW  write data.
REQ-015 bw_0  out  DW  bit-write enable.
REQ-016 dout_0  in  DW  read data, valid LATENCY cycles after read_0 (same cycle when LATENCY=0).
REQ-017 busy  out  1  run in progress.
REQ-018 done  out  1  run complete; held until next start or reset.
REQ-019 fail  out  1  at least one compare mismatch in the current or last run.
REQ-020 fail_bank  out  BAW  bank of first mismatch.
REQ-021 fail_addr  out  AW  address of first mismatch.
REQ-022 err_count  out  16  mismatch count, saturating at 16'hFFFF.

Function
REQ-023 The block SHALL run a March C- algorithm over all N = BANKS*WORDS locations, location order addr-minor, bank-major (addr 0..WORDS-1 within bank 0, then bank 1, ...).
REQ-024 FSM states SHALL be IDLE, M0 (up: W0), M1 (up: R0,W1), M2 (down: R1,W0), M3 (up: R0), DRAIN, DONE.
REQ-025 IDLE or DONE with start=1 SHALL go to M0 next cycle, clear fail, fail_bank, fail_addr, err_count and done; start while busy SHALL be ignored.
REQ-026 Each location in M1/M2 SHALL take two consecutive cycles: read cycle then write cycle to the same bank/addr; M0 and M3 take one cycle per location.
REQ-027 read_0 and write_0 SHALL never be asserted in the same cycle and SHALL be 0 outside M0-M3.
REQ-028 Writes SHALL drive bw_0 all ones and din_0 all zeros (W0) or all ones (W1); din_0 and bw_0 SHALL be 0 when write_0=0.
REQ-029 Up elements SHALL start at bank 0 addr 0 and end at bank BANKS-1 addr WORDS-1; down elements the reverse; the address counter SHALL wrap/borrow between banks without skipped or repeated locations.
REQ-030 After the final location of an element the next element SHALL start the next cycle with no idle cycle; after M3, DRAIN SHALL last exactly LATENCY cycles (zero cycles when LATENCY=0).
REQ-031 busy SHALL be 1 in M0..DRAIN; done SHALL rise, and busy fall, exactly 6N+LATENCY cycles after busy rises.
REQ-032 Each read SHALL push {expected data, bank, addr} into a LATENCY-deep compare pipeline; when the entry emerges, dout_0 SHALL be compared to expected (zeros for R0, ones for R1).
REQ-033 On mismatch err_count SHALL increment (saturating) and fail SHALL set; fail_bank/fail_addr SHALL capture only the first mismatch of the run.
REQ-034 The final read's compare SHALL complete in the last DRAIN cycle, before done rises.
REQ-035 Memory contents after a passing run SHALL be all zeros.

Reset
REQ-036 rst asserted SHALL immediately force IDLE and drive read_0, write_0, busy, done, fail to 0, bank_0, addr_0, din_0, bw_0, fail_bank, fail_addr, err_count to 0, and flush the compare pipeline, including mid-run; no compare SHALL fire from pre-reset reads.

Verification
REQ-037 WORDS=4, BANKS=2, LATENCY=2 with correct memory model, start pulse -> busy for 50 cycles, done=1, fail=0, err_count=0, port sequence matches March C- exactly.
REQ-038 Same config, bench flips dout_0 bit 3 on the compare for bank 1 addr 2 in M1 -> fail=1, fail_bank=1, fail_addr=2, err_count=1.
REQ-039 Memory model with bank 0 addr 1 bit 0 stuck-at-1 -> first mismatch bank 0 addr 1 (M1 R0), err_count=2 (M1 and M3 R0 reads).
REQ-040 LATENCY=0, WORDS=4, BANKS=1 -> busy 24 cycles, no DRAIN, pass.
REQ-041 rst asserted in M2 then released, new start -> clean full run, pass, no stale compares; start pulsed while busy -> no effect on sequence.
REQ-042 Every cycle: assert read_0&write_0 never both 1 and addr_0<WORDS, bank_0<BANKS whenever either is 1.
